imem_loader: RTL and testbench

//  Boot-time program loader sitting upstream of the single-cycle CPU's instruction memory.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Package for the boot-time instruction-memory loader.
// Holds the loader FSM state encoding and the default word capacity.
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH = 128;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte-to-word packer for the instruction-memory loader.
// Assembles four accepted bytes into one little-endian 32-bit word
// (first byte -> [7:0]) and pulses word_valid for one cycle with the
// completed word, the cycle after the fourth byte is taken.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   take       a payload byte is accepted this cycle
//   data       the payload byte
//   word_valid one-cycle pulse: word holds a freshly completed word
//   word       assembled word (held until the next word completes)
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        take,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] sreg;  // first three bytes; newest byte enters at the top

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= 2'd0;
            sreg       <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (take) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    word       <= {data, sreg};
                    word_valid <= 1'b1;
                end else begin
                    sreg <= {data, sreg[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader in front of the CPU instruction memory.
// Accepts LEN_LO, LEN_HI (word count N), 4*N payload bytes and an XOR
// checksum byte; writes packed little-endian words from address 0 upward
// and keeps the CPU in reset until a load completes with a good checksum.
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   in_valid/in_data/in_ready   byte-stream handshake
//   imem_we/imem_addr/imem_wdata  one-cycle instruction-memory write
//   cpu_rst        active-high CPU reset, released only in DONE
//   load_done      sticky: load completed, checksum good
//   load_err       sticky: length overflow or checksum mismatch
//   words_loaded   number of words written so far
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    state_t      state;
    logic [15:0] len;
    logic [7:0]  csum;
    logic        accept;
    logic        last_wr;
    logic        take;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] next_count;
    logic [15:0] hdr_len;

    assign accept     = in_valid && in_ready;
    assign next_count = 16'(words_loaded) + 16'd1;
    assign hdr_len    = {in_data, len[7:0]};

    // Write cycle of the final word. in_ready stays high here, so a byte
    // accepted in this cycle is already the checksum byte and must bypass
    // the packer and the running XOR.
    assign last_wr = (state == DATA) && word_valid && (next_count == len);
    assign take    = accept && (state == DATA) && !last_wr;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .take       (take),
        .data       (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // The packer outputs are registers; the write port is driven straight
    // from them so the word lands exactly one cycle after its fourth byte.
    assign imem_we    = word_valid;
    assign imem_wdata = word;
    assign imem_addr  = words_loaded[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= LEN0;
            len          <= 16'd0;
            csum         <= 8'd0;
            in_ready     <= 1'b0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            in_ready <= 1'b1;
            case (state)
                LEN0: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        if (hdr_len > 16'(DEPTH)) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (hdr_len == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (take)
                        csum <= csum ^ in_data;
                    if (word_valid) begin
                        words_loaded <= words_loaded + (ADDR_W+1)'(1);
                        if (last_wr) begin
                            if (accept) begin
                                in_ready <= 1'b0;
                                if (in_data == csum) begin
                                    state     <= DONE;
                                    load_done <= 1'b1;
                                    cpu_rst   <= 1'b0;
                                end else begin
                                    state    <= ERR;
                                    load_err <= 1'b1;
                                end
                            end else begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_rst   <= 1'b0;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                DONE: in_ready <= 1'b0;
                ERR:  in_ready <= 1'b0;
                default: begin
                    state    <= ERR;
                    load_err <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader. A queue-based model turns
// each generated stream into the expected list of memory writes and the
// expected final status.
module tb_imem_loader;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int gap_pct = 0;

    logic [7:0]  payload[$];
    logic [38:0] wr_q[$];   // {addr, data} of every observed write

    always @(negedge clk)
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte until it is accepted. With chk_we set, the previous
    // accepted byte completed a word, so the write must be visible now.
    task automatic send_byte(input logic [7:0] b, input bit chk_we);
        bit sent = 1'b0;
        int tries = 0;
        while (!sent) begin
            @(negedge clk);
            if (chk_we && tries == 0) check("we_latency", 32'(imem_we), 32'd1);
            tries++;
            if (tries > 500) begin
                check("send_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            if (32'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready) begin
                    @(posedge clk);
                    sent = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"},       32'(imem_we), 32'd0);
        check({tag, "_addr"},     32'(imem_addr), 32'd0);
        check({tag, "_wdata"},    imem_wdata, 32'd0);
        check({tag, "_cpu_rst"},  32'(cpu_rst), 32'd1);
        check({tag, "_done"},     32'(load_done), 32'd0);
        check({tag, "_err"},      32'(load_err), 32'd0);
        check({tag, "_words"},    32'(words_loaded), 32'd0);
    endtask

    // Sends header + payload (module queue) + checksum, then compares the
    // observed writes and final status with what the stream rules imply.
    task automatic run_stream(input string tag, input int n, input bit force_cs,
                              input logic [7:0] forced);
        logic [7:0]  exp_cs = 8'd0;
        logic [7:0]  cs;
        logic [31:0] exp_word;
        bit          overflow = (n > DEPTH);
        bit          good;
        int          exp_writes;
        foreach (payload[i]) exp_cs = exp_cs ^ payload[i];
        cs = force_cs ? forced : exp_cs;
        wr_q.delete();
        send_byte(8'(n), 1'b0);
        send_byte(8'(n >> 8), 1'b0);
        if (!overflow) begin
            foreach (payload[i]) send_byte(payload[i], i > 0 && i % 4 == 0);
            send_byte(cs, n > 0);
        end
        idle(3);
        exp_writes = overflow ? 0 : n;
        good = !overflow && (cs == exp_cs);
        check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < wr_q.size(); i++) begin
            exp_word = 32'(payload[4*i]) + (32'(payload[4*i+1]) << 8)
                     + (32'(payload[4*i+2]) << 16) + (32'(payload[4*i+3]) << 24);
            check({tag, "_wr_addr"}, 32'(wr_q[i][38:32]), 32'(i));
            check({tag, "_wr_data"}, wr_q[i][31:0], exp_word);
        end
        check({tag, "_done"},     32'(load_done), 32'(good));
        check({tag, "_err"},      32'(load_err), 32'(!good));
        check({tag, "_cpu_rst"},  32'(cpu_rst), 32'(!good));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_words"},    32'(words_loaded), 32'(exp_writes));
    endtask

    initial begin
        // reset state while rst is held low
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b1;

        // 1: two-word program, correct checksum (XOR of this payload is 0xC0)
        payload = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_stream("t1", 2, 1'b0, 8'h00);

        // 2: same program, checksum byte 00 does not match
        do_reset();
        run_stream("t2", 2, 1'b1, 8'h00);

        // 3: header over capacity
        do_reset();
        payload.delete();
        run_stream("t3", 129, 1'b0, 8'h00);

        // 4: empty program
        do_reset();
        run_stream("t4", 0, 1'b0, 8'h00);

        // 5: full capacity with random gaps
        do_reset();
        gap_pct = 40;
        payload.delete();
        repeat (4 * DEPTH) payload.push_back(8'($urandom));
        run_stream("t5", DEPTH, 1'b0, 8'h00);

        // 6: reset mid-payload, then a fresh one-word stream
        do_reset();
        gap_pct = 0;
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), i == 4);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("t6");
        rst = 1'b1;
        payload.delete();
        repeat (4) payload.push_back(8'($urandom));
        run_stream("t6", 1, 1'b0, 8'h00);

        // random short streams, half with a corrupted checksum
        gap_pct = 30;
        for (int k = 0; k < 6; k++) begin
            int  n   = 32'($urandom_range(1, 6));
            bit  bad = 1'($urandom_range(1));
            logic [7:0] x = 8'h00;
            do_reset();
            payload.delete();
            repeat (4 * n) payload.push_back(8'($urandom));
            foreach (payload[i]) x = x ^ payload[i];
            run_stream("rnd", n, bad, x ^ 8'($urandom_range(1, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
